// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Desc     : PS/2 device-to-host frame receiver feeding a show-ahead scan-code
//            FIFO with sticky parity / framing / overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_clk,
  input  logic       key_data,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int              c_AW      = $clog2(DEPTH);
  localparam int              c_TW      = $clog2(TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchronisers reset high: an idle PS/2 bus is pulled up
  logic r_kclk_m, r_kclk_s, r_kclk_d;
  logic r_kdat_m, r_kdat_s;
  logic w_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kclk_m <= 1'b1;
      r_kclk_s <= 1'b1;
      r_kclk_d <= 1'b1;
      r_kdat_m <= 1'b1;
      r_kdat_s <= 1'b1;
    end else begin
      r_kclk_m <= key_clk;
      r_kclk_s <= r_kclk_m;
      r_kclk_d <= r_kclk_s;
      r_kdat_m <= key_data;
      r_kdat_s <= r_kdat_m;
    end
  end

  assign w_fall = r_kclk_d & ~r_kclk_s;

  state_t          r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [c_TW-1:0] r_to_cnt;
  logic            w_timeout;
  logic            w_stop_fall;
  logic            w_odd;
  logic            w_stop_bad;
  logic            w_par_bad;
  logic            w_good;

  // An edge arriving on the last counter value still counts as in time
  assign w_timeout   = (r_state != S_IDLE) && !w_fall && (r_to_cnt == c_TO_LAST);
  assign w_stop_fall = (r_state == S_STOP) && w_fall;
  assign w_odd       = ^{r_shift, r_par};
  assign w_stop_bad  = w_stop_fall && !r_kdat_s;
  assign w_par_bad   = w_stop_fall && r_kdat_s && !w_odd;
  assign w_good      = w_stop_fall && r_kdat_s && w_odd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else if (w_timeout) begin
      r_state  <= S_IDLE;
      r_to_cnt <= '0;
    end else if (w_fall) begin
      r_to_cnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (!r_kdat_s) begin
            r_state   <= S_DATA;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
          end
        end
        S_DATA: begin
          r_shift   <= {r_kdat_s, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_state <= S_PARITY;
          end
        end
        S_PARITY: begin
          r_par   <= r_kdat_s;
          r_state <= S_STOP;
        end
        default: r_state <= S_IDLE;
      endcase
    end else if (r_state != S_IDLE) begin
      r_to_cnt <= r_to_cnt + c_TW'(1);
    end
  end

  // Pointers carry one extra wrap bit to tell full from empty
  logic [c_AW:0] r_wr_ptr, r_rd_ptr;
  logic [7:0]    r_mem [DEPTH];
  logic          w_empty, w_full, w_pop, w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {c_AW{1'b0}}});
  assign w_pop   = rd_en && !w_empty;
  assign w_push  = w_good && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= r_shift;
  end

  logic r_parity_err, r_frame_err, r_overflow;

  // A new error event in the same cycle as err_clr leaves the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_par_bad)                    r_parity_err <= 1'b1;
      else if (err_clr)                 r_parity_err <= 1'b0;
      if (w_stop_bad || w_timeout)      r_frame_err  <= 1'b1;
      else if (err_clr)                 r_frame_err  <= 1'b0;
      if (w_good && w_full && !w_pop)   r_overflow   <= 1'b1;
      else if (err_clr)                 r_overflow   <= 1'b0;
    end
  end

  assign code       = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_AW-1:0]];
  assign code_valid = !w_empty;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire
